// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq
// Avalon-MM slave input port for board switches and buttons. Each of the
// WIDTH inputs is synchronised, optionally debounced, and presented as a
// readable "data" register. Accepted transitions of the selected polarity set
// sticky write-1-to-clear capture flags. These are masked into a level
// interrupt.
//
// Register map (word offsets):
//    0  data          RO   debounced input value, zero-extended
//    1  reserved      RO   reads 0
//    2  irq_mask      RW   bits [WIDTH-1:0]
//    3  edge_capture  W1C  sticky edge flags
//
// Ports:
//    clk         system clock
//    reset_n     asynchronous active-low reset
//    address     Avalon word address
//    chipselect  slave select
//    write_n     active-low write strobe
//    writedata   write data (bits at or above WIDTH ignored)
//    readdata    registered read data, 1-clock latency, address-driven
//    in_port     asynchronous external inputs
//    irq         level interrupt, |(edge_capture & irq_mask)

module pio_in_edge_irq #(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_TYPE       = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   // ------------------------------------------------------------------
   // Synchroniser: element 0 samples the pin; the last element is the
   // first point where the value is safe to use.
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
   logic [WIDTH-1:0]                  sync;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_port};
      end
   end

   assign sync = sync_reg[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce: stable_next is the value stable_reg takes at the next
   // edge. The edge detector compares it against stable_reg, so an edge
   // event coincides with the edge that updates stable_reg.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] stable_reg;
   logic [WIDTH-1:0] stable_next;

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
         assign stable_next = sync;
      end else begin : g_debounce
         localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
         localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic          cnt_hit;

            assign cnt_hit = (cnt_reg == CNT_MAX);

            // Accept only once the differing value has been seen for the
            // full count; any return to the stable value restarts it.
            assign stable_next[gi] = (sync[gi] != stable_reg[gi] && cnt_hit)
                                     ? sync[gi] : stable_reg[gi];

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  cnt_reg <= '0;
               end else if (sync[gi] == stable_reg[gi] || cnt_hit) begin
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Edge events
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] edge_event;

   assign rise = stable_next & ~stable_reg;
   assign fall = ~stable_next & stable_reg;

   generate
      if (EDGE_TYPE == 0) begin : g_edge_rise
         assign edge_event = rise;
      end else if (EDGE_TYPE == 1) begin : g_edge_fall
         assign edge_event = fall;
      end else begin : g_edge_any
         assign edge_event = rise | fall;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Bus write decode
   // ------------------------------------------------------------------
   logic             wr_en;
   logic [WIDTH-1:0] wr_bits;
   logic [WIDTH-1:0] clear_bits;
   logic             unused_wdata;

   assign wr_en      = chipselect & ~write_n;
   assign wr_bits    = writedata[WIDTH-1:0];
   assign clear_bits = (wr_en && address == 2'd3) ? wr_bits : '0;

   // Upper writedata bits have no destination; folded here so they are
   // visibly consumed.
   assign unused_wdata = ^writedata;

   // ------------------------------------------------------------------
   // Register state
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] irq_mask_reg;
   logic [WIDTH-1:0] edge_capture_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_reg       <= '0;
         irq_mask_reg     <= '0;
         edge_capture_reg <= '0;
      end else begin
         stable_reg <= stable_next;
         if (wr_en && address == 2'd2) begin
            irq_mask_reg <= wr_bits;
         end
         // OR-ing the event in after the clear makes a same-cycle set win.
         edge_capture_reg <= (edge_capture_reg & ~clear_bits) | edge_event;
      end
   end

   // ------------------------------------------------------------------
   // Read path: registered every clock regardless of chipselect.
   // ------------------------------------------------------------------
   logic [31:0] read_mux;

   always_comb begin
      read_mux = '0;
      case (address)
         2'd0:    read_mux[WIDTH-1:0] = stable_reg;
         2'd2:    read_mux[WIDTH-1:0] = irq_mask_reg;
         2'd3:    read_mux[WIDTH-1:0] = edge_capture_reg;
         default: read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= read_mux;
      end
   end

   // Both operands are registers, so irq has no path from pins or bus.
   assign irq = |(edge_capture_reg & irq_mask_reg);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Testbench for pio_in_edge_irq. Four instances share clock, reset, bus and
// pins; each scenario observes only the instance whose parameters it targets:
//    dut_a: DEBOUNCE 0, rising    (reset/read, irq/mask, collision)
//    dut_b: DEBOUNCE 4, any edge  (debounce, both-edge capture)
//    dut_c: DEBOUNCE 0, falling   (edge type)
//    dut_d: DEBOUNCE 8, rising    (reset mid-debounce)
// Expected read data is pushed to a queue when the read address is driven
// and popped when the registered readdata appears one clock later.

module tb_pio_in_edge_irq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] rd_a, rd_b, rd_c, rd_d;
   logic        irq_a, irq_b, irq_c, irq_d;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   always #5 clk = ~clk;

   pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a));

   pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(in_port), .irq(irq_b));

   pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut_c (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_c), .in_port(in_port), .irq(irq_c));

   pio_in_edge_irq #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0)) dut_d (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd_d), .in_port(in_port), .irq(irq_d));

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic apply_reset(input logic [3:0] pins);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
      in_port    = pins;
      reset_n    = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic issue_read(input logic [1:0] a, input logic [31:0] e);
      address = a;
      exp_q.push_back(e);
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
      in_port    = 4'b1010;
      reset_n    = 1'b0;
      tick();
      checks++;
      if (rd_a !== 32'h0) begin
         errors++;
         $display("FAIL reset_readdata: readdata=%h expected=%h", rd_a, 32'h0);
      end else $display("check reset_readdata: %h", rd_a);
      checks++;
      if (irq_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq: irq=%b expected=0", irq_a);
      end else $display("check reset_irq: %b", irq_a);
      tick();
      reset_n = 1'b1;
      // Pin sampled at edge 1, sync at edge 2, stable at edge 3, readdata at edge 4.
      for (int i = 1; i <= 4; i++) begin
         issue_read(2'd0, (i == 4) ? 32'hA : 32'h0);
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_a !== exp_v) begin
            errors++;
            $display("FAIL reset_latency cycle %0d: readdata=%h expected=%h", i, rd_a, exp_v);
         end else $display("read reset_latency cycle %0d: %h", i, rd_a);
      end
      issue_read(2'd1, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL reset_reserved: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read reset_reserved: %h", rd_a);
      issue_read(2'd2, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL reset_mask: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read reset_mask: %h", rd_a);
      issue_read(2'd3, 32'hA);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL reset_capture: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read reset_capture: %h", rd_a);
      checks++;
      if (irq_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq_unmasked: irq=%b expected=0", irq_a);
      end else $display("check reset_irq_unmasked: %b", irq_a);
   endtask

   // ------------------------------------------------------------------
   task automatic test_debounce();
      apply_reset(4'b0000);
      ticks(3);
      in_port = 4'b0001;
      ticks(3);
      in_port = 4'b0000;
      ticks(10);
      issue_read(2'd0, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_b !== exp_v) begin
         errors++;
         $display("FAIL db_glitch_data: readdata=%h expected=%h", rd_b, exp_v);
      end else $display("read db_glitch_data: %h", rd_b);
      issue_read(2'd3, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_b !== exp_v) begin
         errors++;
         $display("FAIL db_glitch_capture: readdata=%h expected=%h", rd_b, exp_v);
      end else $display("read db_glitch_capture: %h", rd_b);
      // Held high: sync at edge 2, stable at edge 2+4=6, readdata at edge 7.
      in_port = 4'b0001;
      for (int i = 1; i <= 7; i++) begin
         issue_read(2'd0, (i == 7) ? 32'h1 : 32'h0);
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_b !== exp_v) begin
            errors++;
            $display("FAIL db_latency cycle %0d: readdata=%h expected=%h", i, rd_b, exp_v);
         end else $display("read db_latency cycle %0d: %h", i, rd_b);
      end
      issue_read(2'd3, 32'h1);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_b !== exp_v) begin
         errors++;
         $display("FAIL db_capture_rise: readdata=%h expected=%h", rd_b, exp_v);
      end else $display("read db_capture_rise: %h", rd_b);
      bus_write(2'd3, 32'h1);
      issue_read(2'd3, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_b !== exp_v) begin
         errors++;
         $display("FAIL db_capture_cleared: readdata=%h expected=%h", rd_b, exp_v);
      end else $display("read db_capture_cleared: %h", rd_b);
      in_port = 4'b0000;
      ticks(12);
      issue_read(2'd3, 32'h1);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_b !== exp_v) begin
         errors++;
         $display("FAIL db_capture_fall_any: readdata=%h expected=%h", rd_b, exp_v);
      end else $display("read db_capture_fall_any: %h", rd_b);
   endtask

   // ------------------------------------------------------------------
   task automatic test_edge_type();
      apply_reset(4'b0000);
      ticks(3);
      in_port = 4'b0100;
      ticks(5);
      issue_read(2'd0, 32'h4);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_c !== exp_v) begin
         errors++;
         $display("FAIL et_data_rise: readdata=%h expected=%h", rd_c, exp_v);
      end else $display("read et_data_rise: %h", rd_c);
      issue_read(2'd3, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_c !== exp_v) begin
         errors++;
         $display("FAIL et_capture_after_rise: readdata=%h expected=%h", rd_c, exp_v);
      end else $display("read et_capture_after_rise: %h", rd_c);
      in_port = 4'b0000;
      ticks(5);
      issue_read(2'd3, 32'h4);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_c !== exp_v) begin
         errors++;
         $display("FAIL et_capture_after_fall: readdata=%h expected=%h", rd_c, exp_v);
      end else $display("read et_capture_after_fall: %h", rd_c);
   endtask

   // ------------------------------------------------------------------
   task automatic test_irq_mask();
      apply_reset(4'b0000);
      ticks(3);
      bus_write(2'd2, 32'hFFFF_FFF0);
      issue_read(2'd2, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL mask_upper_ignored: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read mask_upper_ignored: %h", rd_a);
      bus_write(2'd0, 32'hF);
      bus_write(2'd1, 32'hF);
      issue_read(2'd0, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL data_read_only: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read data_read_only: %h", rd_a);
      issue_read(2'd1, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL reserved_ignored: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read reserved_ignored: %h", rd_a);
      bus_write(2'd2, 32'h8);
      issue_read(2'd2, 32'h8);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL mask_readback: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read mask_readback: %h", rd_a);
      in_port = 4'b1001;
      ticks(5);
      checks++;
      if (irq_a !== 1'b1) begin
         errors++;
         $display("FAIL irq_bit3: irq=%b expected=1", irq_a);
      end else $display("check irq_bit3: %b", irq_a);
      issue_read(2'd3, 32'h9);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL capture_bits_0_3: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read capture_bits_0_3: %h", rd_a);
      bus_write(2'd3, 32'h8);
      checks++;
      if (irq_a !== 1'b0) begin
         errors++;
         $display("FAIL irq_after_w1c: irq=%b expected=0", irq_a);
      end else $display("check irq_after_w1c: %b", irq_a);
      issue_read(2'd3, 32'h1);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL capture_after_w1c: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read capture_after_w1c: %h", rd_a);
      bus_write(2'd2, 32'h1);
      checks++;
      if (irq_a !== 1'b1) begin
         errors++;
         $display("FAIL irq_unmask: irq=%b expected=1", irq_a);
      end else $display("check irq_unmask: %b", irq_a);
      bus_write(2'd2, 32'h0);
      checks++;
      if (irq_a !== 1'b0) begin
         errors++;
         $display("FAIL irq_mask_off: irq=%b expected=0", irq_a);
      end else $display("check irq_mask_off: %b", irq_a);
      issue_read(2'd3, 32'h1);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL capture_kept_masked: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read capture_kept_masked: %h", rd_a);
   endtask

   // ------------------------------------------------------------------
   task automatic test_collision();
      // Continues from test_irq_mask: in_port=1001, capture=0x1.
      bus_write(2'd3, 32'hF);
      bus_write(2'd2, 32'h2);
      // Bit1 pin sampled at edge 1, stable/capture set at edge 3; the W1C
      // is placed on edge 3 as well.
      in_port = 4'b1011;
      tick();
      tick();
      address    = 2'd3;
      writedata  = 32'h2;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      checks++;
      if (irq_a !== 1'b1) begin
         errors++;
         $display("FAIL collision_irq: irq=%b expected=1", irq_a);
      end else $display("check collision_irq: %b", irq_a);
      issue_read(2'd3, 32'h2);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL collision_capture: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read collision_capture: %h", rd_a);
      bus_write(2'd3, 32'h2);
      issue_read(2'd3, 32'h0);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_a !== exp_v) begin
         errors++;
         $display("FAIL w1c_alone: readdata=%h expected=%h", rd_a, exp_v);
      end else $display("read w1c_alone: %h", rd_a);
      checks++;
      if (irq_a !== 1'b0) begin
         errors++;
         $display("FAIL irq_after_clear: irq=%b expected=0", irq_a);
      end else $display("check irq_after_clear: %b", irq_a);
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_mid();
      apply_reset(4'b0000);
      ticks(3);
      bus_write(2'd2, 32'h1);
      issue_read(2'd2, 32'h1);
      in_port = 4'b0001;
      // Sync high at edge 2; count reaches 5 after edge 7.
      ticks(7);
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_d !== exp_v) begin
         errors++;
         $display("FAIL mid_pre_reset_mask: readdata=%h expected=%h", rd_d, exp_v);
      end else $display("read mid_pre_reset_mask: %h", rd_d);
      reset_n = 1'b0;
      #1;
      checks++;
      if (rd_d !== 32'h0 || irq_d !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs: readdata=%h irq=%b expected=0/0", rd_d, irq_d);
      end else $display("check mid_reset_outputs: %h %b", rd_d, irq_d);
      address = 2'd0;
      tick();
      tick();
      reset_n = 1'b1;
      // Full latency again: stable at edge 1+1+8=10, readdata at edge 11.
      for (int i = 1; i <= 11; i++) begin
         issue_read(2'd0, (i == 11) ? 32'h1 : 32'h0);
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if (rd_d !== exp_v) begin
            errors++;
            $display("FAIL mid_reset_latency cycle %0d: readdata=%h expected=%h", i, rd_d, exp_v);
         end else $display("read mid_reset_latency cycle %0d: %h", i, rd_d);
      end
      issue_read(2'd3, 32'h1);
      tick();
      exp_v = exp_q.pop_front();
      checks++;
      if (rd_d !== exp_v) begin
         errors++;
         $display("FAIL mid_reset_capture: readdata=%h expected=%h", rd_d, exp_v);
      end else $display("read mid_reset_capture: %h", rd_d);
      checks++;
      if (irq_d !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_mask_cleared: irq=%b expected=0", irq_d);
      end else $display("check mid_reset_mask_cleared: %b", irq_d);
   endtask

   // ------------------------------------------------------------------
   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd0;
      writedata  = '0;
      in_port    = 4'b0000;
      test_reset();
      test_debounce();
      test_edge_type();
      test_irq_mask();
      test_collision();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
      $fatal(1, "timeout");
   end

endmodule
